// File: rtl/elliptic_curve_structs.sv
// Shared curve types plus the MSM sequencer state encoding and scalar width.
package elliptic_curve_structs;

    localparam int SCALAR_W = 256;

    typedef struct packed {
        logic [SCALAR_W-1:0] x;
        logic [SCALAR_W-1:0] y;
    } curve_point_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        MUL_GO   = 3'd2,
        MUL_WAIT = 3'd3,
        ADD_GO   = 3'd4,
        ADD_WAIT = 3'd5,
        FIN      = 3'd6
    } msm_state_t;

endpackage

// File: rtl/msm_op_launcher.sv
// Start-pulse / Done handshake for one arithmetic unit: reset is held except while
// the unit runs, and Done is masked in the first cycle after the pulse.
module msm_op_launcher (
    input  logic clk,
    input  logic Reset,
    input  logic go,
    input  logic unit_done,
    output logic unit_reset,
    output logic fin
);

    logic wait_r;
    logic first_r;

    // Track the running window; first_r blanks a Done that may be stale from the pulse cycle
    always_ff @(posedge clk) begin
        if (Reset) begin
            wait_r  <= 1'b0;
            first_r <= 1'b0;
        end else if (go) begin
            wait_r  <= 1'b1;
            first_r <= 1'b1;
        end else if (wait_r) begin
            first_r <= 1'b0;
            if (unit_done && !first_r) begin
                wait_r <= 1'b0;
            end else begin
                wait_r <= 1'b1;
            end
        end else begin
            wait_r  <= 1'b0;
            first_r <= 1'b0;
        end
    end

    assign unit_reset = Reset | ~wait_r;
    assign fin        = wait_r & ~first_r & unit_done;

endmodule

// File: rtl/msm_sequencer.sv
// Multi-scalar multiplication sequencer: streams (P_i, k_i), multiplies, accumulates.
// Optional MSM_PERF_CNT_EN adds perf_cycles / perf_muls counters.
module msm_sequencer
    import elliptic_curve_structs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_pairs,
    input  logic                in_valid,
    output logic                in_ready,
    input  curve_point_t        in_P,
    input  logic [SCALAR_W-1:0] in_k,
    output logic                mul_reset,
    output curve_point_t        mul_P,
    output logic [SCALAR_W-1:0] mul_k,
    input  logic                mul_done,
    input  curve_point_t        mul_R,
    output logic                add_reset,
    output curve_point_t        add_P,
    output curve_point_t        add_Q,
    input  logic                add_done,
    input  curve_point_t        add_R,
    output logic                busy,
    output logic                done,
    output logic                is_infinity,
    output curve_point_t        result
`ifdef MSM_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles,
    output logic [CNT_W-1:0]    perf_muls
`endif
);

    msm_state_t          state_r;
    msm_state_t          next_state_s;
    msm_state_t          next_pair_s;
    logic [CNT_W-1:0]    num_r;
    logic [CNT_W-1:0]    idx_r;
    curve_point_t        acc_r;
    logic                acc_valid_r;
    curve_point_t        mul_p_r;
    logic [SCALAR_W-1:0] mul_k_r;
    curve_point_t        add_p_r;
    curve_point_t        add_q_r;
    curve_point_t        result_r;
    logic                is_inf_r;
    logic                done_r;
    logic                busy_r;
    logic                in_ready_r;
    logic                in_ready_next_s;
    logic                hs_s;
    logic                mul_go_s;
    logic                add_go_s;
    logic                mul_fin_s;
    logic                add_fin_s;

    assign hs_s        = (state_r == FETCH) && in_valid && in_ready_r;
    assign next_pair_s = (idx_r == num_r) ? FIN : FETCH;

    msm_op_launcher u_mul_launch (
        .clk        (clk),
        .Reset      (Reset),
        .go         (mul_go_s),
        .unit_done  (mul_done),
        .unit_reset (mul_reset),
        .fin        (mul_fin_s)
    );

    msm_op_launcher u_add_launch (
        .clk        (clk),
        .Reset      (Reset),
        .go         (add_go_s),
        .unit_done  (add_done),
        .unit_reset (add_reset),
        .fin        (add_fin_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (num_pairs == {CNT_W{1'b0}}) ? FIN : FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (hs_s) begin
                    if (in_k == {SCALAR_W{1'b0}}) begin
                        next_state_s = ((idx_r + {{(CNT_W-1){1'b0}}, 1'b1}) == num_r) ? FIN : FETCH;
                    end else begin
                        next_state_s = MUL_GO;
                    end
                end else begin
                    next_state_s = FETCH;
                end
            end
            MUL_GO:   next_state_s = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_fin_s) begin
                    next_state_s = acc_valid_r ? ADD_GO : next_pair_s;
                end else begin
                    next_state_s = MUL_WAIT;
                end
            end
            ADD_GO:   next_state_s = ADD_WAIT;
            ADD_WAIT: begin
                if (add_fin_s) begin
                    next_state_s = next_pair_s;
                end else begin
                    next_state_s = ADD_WAIT;
                end
            end
            FIN:      next_state_s = IDLE;
            default:  next_state_s = IDLE;
        endcase
    end

    // Output decode: launcher kicks and the next value of in_ready
    always_comb begin
        mul_go_s        = (state_r == MUL_GO);
        add_go_s        = (state_r == ADD_GO);
        in_ready_next_s = (next_state_s == FETCH);
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            num_r       <= {CNT_W{1'b0}};
            idx_r       <= {CNT_W{1'b0}};
            acc_r       <= '0;
            acc_valid_r <= 1'b0;
            mul_p_r     <= '0;
            mul_k_r     <= {SCALAR_W{1'b0}};
            add_p_r     <= '0;
            add_q_r     <= '0;
            result_r    <= '0;
            is_inf_r    <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            in_ready_r <= in_ready_next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        num_r       <= num_pairs;
                        idx_r       <= {CNT_W{1'b0}};
                        acc_r       <= '0;
                        acc_valid_r <= 1'b0;
                        done_r      <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (hs_s) begin
                        mul_p_r <= in_P;
                        mul_k_r <= in_k;
                        idx_r   <= idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                MUL_WAIT: begin
                    if (mul_fin_s) begin
                        if (!acc_valid_r) begin
                            acc_r       <= mul_R;
                            acc_valid_r <= 1'b1;
                        end else begin
                            add_p_r <= acc_r;
                            add_q_r <= mul_R;
                        end
                    end
                end
                ADD_WAIT: begin
                    if (add_fin_s) begin
                        acc_r <= add_R;
                    end
                end
                FIN: begin
                    result_r <= acc_r;
                    is_inf_r <= ~acc_valid_r;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

`ifdef MSM_PERF_CNT_EN
    logic [31:0]      perf_cycles_r;
    logic [CNT_W-1:0] perf_muls_r;

    // Busy-cycle and multiplier-launch counters; both freeze once busy drops
    always_ff @(posedge clk) begin
        if (Reset) begin
            perf_cycles_r <= 32'd0;
            perf_muls_r   <= {CNT_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            perf_cycles_r <= 32'd0;
            perf_muls_r   <= {CNT_W{1'b0}};
        end else begin
            if (busy_r && (perf_cycles_r != 32'hFFFF_FFFF)) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end
            if (mul_go_s) begin
                perf_muls_r <= perf_muls_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign perf_cycles = perf_cycles_r;
    assign perf_muls   = perf_muls_r;
`endif

    assign in_ready    = in_ready_r;
    assign mul_P       = mul_p_r;
    assign mul_k       = mul_k_r;
    assign add_P       = add_p_r;
    assign add_Q       = add_q_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign is_infinity = is_inf_r;
    assign result      = result_r;

endmodule

// File: tb/tb_msm_sequencer.sv
// Directed bench for msm_sequencer with behavioural multiplier/adder stand-ins
// using a linear point model (k*P scales both coordinates, addition is componentwise).
module tb_msm_sequencer;
    import elliptic_curve_structs::*;

    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                Reset = 1'b1;
    logic                start = 1'b0;
    logic [CNT_W-1:0]    num_pairs = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    curve_point_t        in_P = '0;
    logic [SCALAR_W-1:0] in_k = '0;
    logic                mul_reset;
    curve_point_t        mul_P;
    logic [SCALAR_W-1:0] mul_k;
    logic                mul_done;
    curve_point_t        mul_R;
    logic                add_reset;
    curve_point_t        add_P;
    curve_point_t        add_Q;
    logic                add_done;
    curve_point_t        add_R;
    logic                busy;
    logic                done;
    logic                is_infinity;
    curve_point_t        result;
`ifdef MSM_PERF_CNT_EN
    logic [31:0]         perf_cycles;
    logic [CNT_W-1:0]    perf_muls;
`endif

    int checks = 0;
    int failures = 0;

    msm_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .start       (start),
        .num_pairs   (num_pairs),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_P        (in_P),
        .in_k        (in_k),
        .mul_reset   (mul_reset),
        .mul_P       (mul_P),
        .mul_k       (mul_k),
        .mul_done    (mul_done),
        .mul_R       (mul_R),
        .add_reset   (add_reset),
        .add_P       (add_P),
        .add_Q       (add_Q),
        .add_done    (add_done),
        .add_R       (add_R),
        .busy        (busy),
        .done        (done),
        .is_infinity (is_infinity),
        .result      (result)
`ifdef MSM_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_muls   (perf_muls)
`endif
    );

    always #5 clk = ~clk;

    function automatic curve_point_t mkpt(input logic [255:0] x, input logic [255:0] y);
        curve_point_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

    // ---------------- behavioural sub-units ----------------
    logic [3:0] mul_cnt = 4'd0;
    logic       mul_done_m = 1'b0;
    logic       mul_reset_d = 1'b1;
    logic [3:0] add_cnt = 4'd0;
    logic       add_done_m = 1'b0;
    logic       add_reset_d = 1'b1;
    logic       early_en = 1'b0;
    int         mul_inv = 0;
    int         add_inv = 0;
    int         rdy_cnt = 0;
    curve_point_t garbage;

    assign garbage = {16{32'hDEAD_BEEF}};

    always @(posedge clk) begin
        mul_reset_d <= mul_reset;
        add_reset_d <= add_reset;
        if (!mul_reset && mul_reset_d) mul_inv <= mul_inv + 1;
        if (!add_reset && add_reset_d) add_inv <= add_inv + 1;
        if (in_ready) rdy_cnt <= rdy_cnt + 1;
        if (mul_reset) begin
            mul_cnt <= 4'd0;
            mul_done_m <= 1'b0;
        end else if (!mul_done_m) begin
            mul_cnt <= mul_cnt + 4'd1;
            if (mul_cnt == 4'd3) mul_done_m <= 1'b1;
        end
        if (add_reset) begin
            add_cnt <= 4'd0;
            add_done_m <= 1'b0;
        end else if (!add_done_m) begin
            add_cnt <= add_cnt + 4'd1;
            if (add_cnt == 4'd1) add_done_m <= 1'b1;
        end
    end

    assign mul_done = mul_done_m | (early_en & ~mul_reset & mul_reset_d);
    assign mul_R    = mul_done_m ? mkpt(mul_P.x * mul_k, mul_P.y * mul_k) : garbage;
    assign add_done = add_done_m;
    assign add_R    = add_done_m ? mkpt(add_P.x + add_Q.x, add_P.y + add_Q.y) : garbage;

    // ---------------- checking and stimulus helpers ----------------
    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        @(negedge clk);
        num_pairs = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pair(input string tag, input curve_point_t p, input logic [255:0] k);
        logic ok;
        ok = 1'b0;
        in_P = p;
        in_k = k;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq({tag, "_accept_timeout"}, 512'd0, 512'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq({tag, "_done_timeout"}, 512'd0, 512'd1);
    endtask

    curve_point_t g;
    curve_point_t g2;
    int base_mul;
    int base_add;
    int base_rdy;

    initial begin
        g  = mkpt(256'd7, 256'd11);
        g2 = mkpt(256'd14, 256'd22);

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_mul_reset", 512'(mul_reset), 512'd1);
        check_eq("rst_add_reset", 512'(add_reset), 512'd1);
        Reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 512'(in_ready), 512'd0);
        check_eq("rst_busy", 512'(busy), 512'd0);
        check_eq("rst_done", 512'(done), 512'd0);
        check_eq("rst_is_inf", 512'(is_infinity), 512'd0);
        check_eq("rst_result", 512'(result), 512'd0);

        // Single pair (G,1)
        base_mul = mul_inv; base_add = add_inv;
        do_start(16'd1);
        check_eq("t1_busy", 512'(busy), 512'd1);
        send_pair("t1p0", g, 256'd1);
        wait_done("t1");
        check_eq("t1_result", 512'(result), 512'(mkpt(256'd7, 256'd11)));
        check_eq("t1_is_inf", 512'(is_infinity), 512'd0);
        check_eq("t1_mul_inv", 512'(mul_inv - base_mul), 512'd1);
        check_eq("t1_add_inv", 512'(add_inv - base_add), 512'd0);

        // (G,1),(G,2) -> 3G
        base_mul = mul_inv; base_add = add_inv;
        do_start(16'd2);
        check_eq("t2_done_cleared", 512'(done), 512'd0);
        send_pair("t2p0", g, 256'd1);
        send_pair("t2p1", g, 256'd2);
        wait_done("t2");
        check_eq("t2_result", 512'(result), 512'(mkpt(256'd21, 256'd33)));
        check_eq("t2_add_inv", 512'(add_inv - base_add), 512'd1);
        check_eq("t2_busy", 512'(busy), 512'd0);

        // num_pairs = 0
        base_rdy = rdy_cnt;
        do_start(16'd0);
        check_eq("t3_done_1cyc", 512'(done), 512'd0);
        @(negedge clk);
        check_eq("t3_done_2cyc", 512'(done), 512'd1);
        check_eq("t3_is_inf", 512'(is_infinity), 512'd1);
        check_eq("t3_busy", 512'(busy), 512'd0);
        repeat (2) @(negedge clk);
        check_eq("t3_in_ready_cnt", 512'(rdy_cnt - base_rdy), 512'd0);
        check_eq("t3_done_held", 512'(done), 512'd1);

        // Zero scalars skipped: (G,0),(2G,0),(G,5) -> 5G
        base_mul = mul_inv;
        do_start(16'd3);
        send_pair("t4p0", g, 256'd0);
        send_pair("t4p1", g2, 256'd0);
        send_pair("t4p2", g, 256'd5);
        wait_done("t4");
        check_eq("t4_result", 512'(result), 512'(mkpt(256'd35, 256'd55)));
        check_eq("t4_is_inf", 512'(is_infinity), 512'd0);
        check_eq("t4_mul_inv", 512'(mul_inv - base_mul), 512'd1);
`ifdef MSM_PERF_CNT_EN
        check_eq("t4_perf_muls", 512'(perf_muls), 512'd1);
`endif

        // Stall with in_valid low, early Done forced in first MUL_WAIT cycle
        base_mul = mul_inv;
        early_en = 1'b1;
        do_start(16'd2);
        repeat (20) @(negedge clk);
        check_eq("t5_stall_ready", 512'(in_ready), 512'd1);
        check_eq("t5_stall_busy", 512'(busy), 512'd1);
        check_eq("t5_stall_mul_inv", 512'(mul_inv - base_mul), 512'd0);
        send_pair("t5p0", g, 256'd2);
        send_pair("t5p1", g, 256'd4);
        wait_done("t5");
        check_eq("t5_result", 512'(result), 512'(mkpt(256'd42, 256'd66)));
        check_eq("t5_mul_inv", 512'(mul_inv - base_mul), 512'd2);
        early_en = 1'b0;

        // Reset in MUL_WAIT of pair 2 of 3, then restart with (G,3)
        base_mul = mul_inv;
        do_start(16'd3);
        send_pair("t6p0", g, 256'd1);
        send_pair("t6p1", g, 256'd2);
        for (int i = 0; i < 50; i++) begin
            if (mul_inv - base_mul >= 2) break;
            @(negedge clk);
        end
        check_eq("t6_in_mul_wait", 512'(mul_reset), 512'd0);
        Reset = 1'b1;
        #1;
        check_eq("t6_mul_reset_in_rst", 512'(mul_reset), 512'd1);
        @(negedge clk);
        check_eq("t6_add_reset_in_rst", 512'(add_reset), 512'd1);
        Reset = 1'b0;
        @(negedge clk);
        check_eq("t6_done_after_rst", 512'(done), 512'd0);
        check_eq("t6_busy_after_rst", 512'(busy), 512'd0);
        check_eq("t6_ready_after_rst", 512'(in_ready), 512'd0);
        do_start(16'd1);
        send_pair("t6p_new", g, 256'd3);
        wait_done("t6");
        check_eq("t6_result", 512'(result), 512'(mkpt(256'd21, 256'd33)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
